// File: rtl/vending_pkg.sv
// Shared definitions for the change dispenser: coin codes, coin unit values
// and the dispenser FSM state encoding.
package vending_pkg;

    typedef enum logic [1:0] {
        M10 = 2'b00,
        M20 = 2'b01,
        M50 = 2'b10
    } coin_t;

    localparam int V10 = 1;
    localparam int V20 = 2;
    localparam int V50 = 5;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ISSUE,
        GAP,
        FINISH
    } state_t;

    function automatic int coin_value(coin_t code);
        case (code)
            M50:     return V50;
            M20:     return V20;
            default: return V10;
        endcase
    endfunction

endpackage

// File: rtl/coin_inventory.sv
// Coin stock for the dispenser: per-denomination counts with bulk load,
// single-coin take and an all-empty flag.
module coin_inventory
    import vending_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_n50,
    input  logic [CNT_W-1:0] load_n20,
    input  logic [CNT_W-1:0] load_n10,
    input  logic             take,
    input  coin_t            take_code,
    output logic [CNT_W-1:0] n50,
    output logic [CNT_W-1:0] n20,
    output logic [CNT_W-1:0] n10,
    output logic             empty
);

    // Slot index equals the coin code: 0 = Rs.10, 1 = Rs.20, 2 = Rs.50.
    logic [CNT_W-1:0] load_val [3];
    logic [CNT_W-1:0] cnt      [3];

    assign load_val[0] = load_n10;
    assign load_val[1] = load_n20;
    assign load_val[2] = load_n50;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (load) begin
                    cnt_reg <= load_val[gi];
                end else if (take && take_code == 2'(gi) && cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
            end

            assign cnt[gi] = cnt_reg;
        end
    endgenerate

    assign n10   = cnt[0];
    assign n20   = cnt[1];
    assign n50   = cnt[2];
    assign empty = (cnt[0] == '0) && (cnt[1] == '0) && (cnt[2] == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays an amount in Rs.50/20/10 coins from a loaded
// inventory, handshaking each coin with the eject mechanism.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMT_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [AMT_W-1:0] Amount,
    input  logic             Load,
    input  logic [CNT_W-1:0] Load_N50,
    input  logic [CNT_W-1:0] Load_N20,
    input  logic [CNT_W-1:0] Load_N10,
    output logic [1:0]       Coin,
    output logic             Coin_Valid,
    input  logic             Coin_Ack,
    output logic             Busy,
    output logic             Done,
    output logic             Short,
    output logic [AMT_W-1:0] Owed,
    output logic             Empty
);

    state_t           state_reg;
    logic [AMT_W-1:0] remaining_reg;
    coin_t            coin_reg;
    logic             coin_valid_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             short_reg;
    logic [AMT_W-1:0] owed_reg;

    logic [CNT_W-1:0] n50, n20, n10;
    logic             pick_valid;
    coin_t            pick_code;
    logic             take;

    assign take = (state_reg == ISSUE) && Coin_Ack;

    coin_inventory #(.CNT_W(CNT_W)) u_inventory (
        .clk       (Clk),
        .rst       (Reset),
        .load      (Load && state_reg == IDLE),
        .load_n50  (Load_N50),
        .load_n20  (Load_N20),
        .load_n10  (Load_N10),
        .take      (take),
        .take_code (coin_reg),
        .n50       (n50),
        .n20       (n20),
        .n10       (n10),
        .empty     (Empty)
    );

    // Largest coin that still fits the remainder and is in stock.
    always_comb begin
        pick_valid = 1'b1;
        pick_code  = M10;
        if (remaining_reg >= AMT_W'(V50) && n50 != '0) begin
            pick_code = M50;
        end else if (remaining_reg >= AMT_W'(V20) && n20 != '0) begin
            pick_code = M20;
        end else if (remaining_reg != '0 && n10 != '0) begin
            pick_code = M10;
        end else begin
            pick_valid = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg      <= IDLE;
            remaining_reg  <= '0;
            coin_reg       <= M10;
            coin_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            short_reg      <= 1'b0;
            owed_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!Load && Start) begin
                        remaining_reg <= Amount;
                        busy_reg      <= 1'b1;
                        state_reg     <= SELECT;
                    end
                end
                SELECT: begin
                    if (pick_valid) begin
                        coin_reg       <= pick_code;
                        coin_valid_reg <= 1'b1;
                        state_reg      <= ISSUE;
                    end else begin
                        done_reg  <= 1'b1;
                        short_reg <= (remaining_reg != '0);
                        owed_reg  <= remaining_reg;
                        state_reg <= FINISH;
                    end
                end
                ISSUE: begin
                    if (Coin_Ack) begin
                        remaining_reg  <= remaining_reg - AMT_W'(coin_value(coin_reg));
                        coin_reg       <= M10;
                        coin_valid_reg <= 1'b0;
                        state_reg      <= GAP;
                    end
                end
                GAP: begin
                    state_reg <= SELECT;
                end
                FINISH: begin
                    done_reg  <= 1'b0;
                    short_reg <= 1'b0;
                    owed_reg  <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign Coin       = coin_reg;
    assign Coin_Valid = coin_valid_reg;
    assign Busy       = busy_reg;
    assign Done       = done_reg;
    assign Short      = short_reg;
    assign Owed       = owed_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed vector table, hand-written
// handshake/reset sequences and randomized transactions against a greedy model.
module tb_change_dispenser;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [3:0] Amount;
    logic       Load;
    logic [3:0] Load_N50, Load_N20, Load_N10;
    logic [1:0] Coin;
    logic       Coin_Valid;
    logic       Coin_Ack;
    logic       Busy, Done, Short;
    logic [3:0] Owed;
    logic       Empty;

    int total = 0;
    int bad   = 0;

    int m50, m20, m10;

    typedef struct {
        bit     ld;
        int     n50, n20, n10, amt;
        longint seq;
        int     sh, ow, emp;
    } vec_t;

    vec_t tbl [9];

    change_dispenser #(.AMT_W(4), .CNT_W(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Amount     (Amount),
        .Load       (Load),
        .Load_N50   (Load_N50),
        .Load_N20   (Load_N20),
        .Load_N10   (Load_N10),
        .Coin       (Coin),
        .Coin_Valid (Coin_Valid),
        .Coin_Ack   (Coin_Ack),
        .Busy       (Busy),
        .Done       (Done),
        .Short      (Short),
        .Owed       (Owed),
        .Empty      (Empty)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic int coin_val(input logic [1:0] code);
        case (code)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 5;
            default: return 9;
        endcase
    endfunction

    task automatic do_load(input int a, input int b, input int c);
        Load = 1'b1;
        Load_N50 = 4'(a);
        Load_N20 = 4'(b);
        Load_N10 = 4'(c);
        step();
        Load = 1'b0;
    endtask

    // Greedy payout computed directly from the coin rules.
    task automatic model_txn(input int amt, output longint seq, output int sh, output int ow);
        int r;
        r   = amt;
        seq = 0;
        forever begin
            if (r >= 5 && m50 > 0) begin
                r -= 5; m50--; seq = seq * 10 + 5;
            end else if (r >= 2 && m20 > 0) begin
                r -= 2; m20--; seq = seq * 10 + 2;
            end else if (r >= 1 && m10 > 0) begin
                r -= 1; m10--; seq = seq * 10 + 1;
            end else begin
                break;
            end
        end
        ow = r;
        sh = (r != 0) ? 1 : 0;
    endtask

    task automatic run_txn(input int amt, input bit rand_delay,
                           output longint seq, output int sh, output int ow);
        bit         done_seen;
        logic [1:0] held;
        int         d;
        seq = 0; sh = 0; ow = 0; done_seen = 0;
        Amount = 4'(amt);
        Start  = 1'b1;
        step();
        Start = 1'b0;
        check("busy_after_start", Busy, 1);
        for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
            step();
            if (Coin_Valid) begin
                held = Coin;
                d = rand_delay ? int'($urandom_range(0, 3)) : 0;
                repeat (d) begin
                    step();
                    check("hold_valid", Coin_Valid, 1);
                    check("hold_code", Coin, held);
                end
                Coin_Ack = 1'b1;
                step();
                Coin_Ack = 1'b0;
                check("gap_low", Coin_Valid, 0);
                seq = seq * 10 + coin_val(held);
            end else if (Done) begin
                sh = Short;
                ow = Owed;
                done_seen = 1;
            end else begin
                check("unqual_coin_zero", Coin, 0);
                check("unqual_owed_zero", Owed, 0);
                check("unqual_short_zero", Short, 0);
            end
        end
        if (!done_seen) check("done_timeout", 0, 1);
        step();
        check("done_one_cycle", Done, 0);
        check("idle_after_done", Busy, 0);
        $display("txn amount=%0d coins=%0d short=%0d owed=%0d", amt, seq, sh, ow);
    endtask

    initial begin
        longint seq, eseq;
        int     sh, ow, esh, eow;

        tbl[0] = '{1, 2, 2, 2,  8, 521,    0, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 15, 521,    1, 7, 1};
        tbl[2] = '{1, 1, 1, 0,  4, 2,      1, 2, 0};
        tbl[3] = '{1, 3, 3, 3,  0, 0,      0, 0, 0};
        tbl[4] = '{1, 1, 3, 0,  6, 5,      1, 1, 0};
        tbl[5] = '{1, 0, 0, 0,  7, 0,      1, 7, 1};
        tbl[6] = '{1, 15, 15, 15, 15, 555, 0, 0, 0};
        tbl[7] = '{1, 1, 1, 5,  9, 5211,   0, 0, 0};
        tbl[8] = '{1, 0, 15, 1, 11, 222221, 0, 0, 0};

        Reset = 1'b1; Start = 1'b0; Amount = '0; Load = 1'b0;
        Load_N50 = '0; Load_N20 = '0; Load_N10 = '0; Coin_Ack = 1'b0;
        #1;
        check("rst_busy", Busy, 0);
        check("rst_valid", Coin_Valid, 0);
        check("rst_done", Done, 0);
        check("rst_short", Short, 0);
        check("rst_owed", Owed, 0);
        check("rst_coin", Coin, 0);
        check("rst_empty", Empty, 1);
        step(); step();
        Reset = 1'b0;
        step();

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].ld) do_load(tbl[i].n50, tbl[i].n20, tbl[i].n10);
            run_txn(tbl[i].amt, 1'b1, seq, sh, ow);
            check($sformatf("vec%0d_coins", i), seq, tbl[i].seq);
            check($sformatf("vec%0d_short", i), sh, tbl[i].sh);
            check($sformatf("vec%0d_owed", i), ow, tbl[i].ow);
            check($sformatf("vec%0d_empty", i), Empty, tbl[i].emp);
        end

        // Amount=0 latency
        do_load(1, 1, 1);
        Amount = 4'd0; Start = 1'b1;
        step();
        Start = 1'b0;
        check("zero_busy_n", Busy, 1);
        check("zero_done_n", Done, 0);
        step();
        check("zero_done_n1", Done, 1);
        check("zero_short", Short, 0);
        check("zero_valid", Coin_Valid, 0);
        step();
        check("zero_idle", Busy, 0);

        // Slow ack with Start/Load pulsed mid-dispense
        do_load(2, 0, 0);
        Amount = 4'd5; Start = 1'b1;
        step();
        Start = 1'b0;
        check("slow_valid_n", Coin_Valid, 0);
        step();
        check("slow_valid_n1", Coin_Valid, 1);
        check("slow_code", Coin, 2);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                Start = 1'b1; Amount = 4'd3;
                Load = 1'b1; Load_N50 = 4'd9; Load_N20 = 4'd9; Load_N10 = 4'd9;
            end
            step();
            Start = 1'b0; Load = 1'b0;
            check("slow_hold_valid", Coin_Valid, 1);
            check("slow_hold_code", Coin, 2);
        end
        Coin_Ack = 1'b1;
        step();
        Coin_Ack = 1'b0;
        check("slow_gap", Coin_Valid, 0);
        step();
        step();
        check("slow_done", Done, 1);
        check("slow_short", Short, 0);
        check("slow_owed", Owed, 0);
        step();
        check("slow_idle", Busy, 0);
        run_txn(10, 1'b0, seq, sh, ow);
        check("slow_load_ignored_coins", seq, 5);
        check("slow_load_ignored_owed", ow, 5);
        check("slow_load_ignored_empty", Empty, 1);

        // Load and Start together; Ack in IDLE
        Load = 1'b1; Load_N50 = 4'd0; Load_N20 = 4'd0; Load_N10 = 4'd1;
        Start = 1'b1; Amount = 4'd1;
        step();
        Load = 1'b0; Start = 1'b0;
        check("ls_no_txn", Busy, 0);
        check("ls_loaded", Empty, 0);
        Coin_Ack = 1'b1;
        step();
        Coin_Ack = 1'b0;
        check("ack_idle_busy", Busy, 0);
        check("ack_idle_valid", Coin_Valid, 0);
        run_txn(2, 1'b0, seq, sh, ow);
        check("ls_coins", seq, 1);
        check("ls_owed", ow, 1);

        // Reset while a coin is presented
        do_load(1, 1, 1);
        Amount = 4'd5; Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        check("rmid_valid_before", Coin_Valid, 1);
        #3;
        Reset = 1'b1;
        #1;
        check("rmid_valid_async", Coin_Valid, 0);
        check("rmid_busy_async", Busy, 0);
        check("rmid_empty_async", Empty, 1);
        step();
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rmid_no_done", Done, 0);
        end
        run_txn(3, 1'b0, seq, sh, ow);
        check("rmid_cleared_coins", seq, 0);
        check("rmid_cleared_owed", ow, 3);

        // Randomized transactions vs greedy model
        for (int i = 0; i < 40; i++) begin
            int amt;
            if (i == 0 || $urandom_range(0, 1) == 1) begin
                m50 = $urandom_range(0, 3);
                m20 = $urandom_range(0, 3);
                m10 = $urandom_range(0, 3);
                do_load(m50, m20, m10);
            end
            amt = $urandom_range(0, 15);
            model_txn(amt, eseq, esh, eow);
            run_txn(amt, 1'b1, seq, sh, ow);
            check($sformatf("rnd%0d_coins", i), seq, eseq);
            check($sformatf("rnd%0d_short", i), sh, esh);
            check($sformatf("rnd%0d_owed", i), ow, eow);
            check($sformatf("rnd%0d_empty", i), Empty,
                  (m50 == 0 && m20 == 0 && m10 == 0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
